// File: rtl/hazard_control_unit.sv
// hazard_control_unit: load-use, branch, jump and memory-freeze control for the 5-stage pipeline.
// Control outputs are combinational from state and inputs; state and event counters are registered.
module hazard_control_unit #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             idex_memread,
    input  logic [4:0]       idex_rt,
    input  logic [4:0]       ifid_rs,
    input  logic [4:0]       ifid_rt,
    input  logic             ifid_uses_rt,
    input  logic             branch_ex_mem,
    input  logic             zero_flag_ex_mem,
    input  logic             jump,
    input  logic             mem_busy,
    output logic             pcwrite,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);
    typedef enum logic [1:0] {RUN, LU_STALL, FREEZE} state_t;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
    logic             lu_haz, br_taken;
    assign lu_haz   = idex_memread && (idex_rt != 5'd0) &&
                      ((idex_rt == ifid_rs) || (ifid_uses_rt && idex_rt == ifid_rt));
    assign br_taken = branch_ex_mem && zero_flag_ex_mem;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
    always_comb begin
        pcwrite     = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        state_d     = RUN;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (!reset) begin
            pcwrite     = 1'b0;
            ifid_write  = 1'b0;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
        end else if (mem_busy) begin
            pcwrite    = 1'b0;
            ifid_write = 1'b0;
            state_d    = FREEZE;
        end else if (br_taken) begin
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
            flush_cnt_d = (&flush_cnt_q) ? flush_cnt_q : flush_cnt_q + 1'b1;
        end else if (jump) begin
            ifid_flush = 1'b1;
        end else if (lu_haz && state_q != LU_STALL) begin
            // FREEZE resolves like RUN, so a held hazard still gets its stall
            pcwrite     = 1'b0;
            ifid_write  = 1'b0;
            idex_flush  = 1'b1;
            state_d     = LU_STALL;
            stall_cnt_d = (&stall_cnt_q) ? stall_cnt_q : stall_cnt_q + 1'b1;
        end
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= RUN;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end
endmodule

// File: tb/tb_hazard_control_unit.sv
// tb_hazard_control_unit: directed scoreboard bench for hazard_control_unit.
// A default-width and a 4-bit-counter instance share all inputs.
module tb_hazard_control_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic        idex_memread, ifid_uses_rt, branch_ex_mem, zero_flag_ex_mem, jump, mem_busy;
    logic [4:0]  idex_rt, ifid_rs, ifid_rt;
    logic        pcwrite, ifid_write, ifid_flush, idex_flush, exmem_flush;
    logic        pcwrite4, ifid_write4, ifid_flush4, idex_flush4, exmem_flush4;
    logic [15:0] stall_cnt, flush_cnt;
    logic [3:0]  stall_cnt4, flush_cnt4;
    logic [4:0]  ctrl, ctrl4;
    int          checks = 0;
    int          errors = 0;
    logic [15:0] m_sc = 0, m_fc = 0;
    logic [3:0]  m_sc4 = 0, m_fc4 = 0;

    localparam logic [4:0] NORM = 5'b11000, STALL = 5'b00010, BR = 5'b11111,
                           JMP = 5'b11100, FRZ = 5'b00000, RST = 5'b00111;

    typedef struct {
        string       tag;
        logic [4:0]  ctrl;
        logic [15:0] sc, fc;
        logic [3:0]  sc4, fc4;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    assign ctrl  = {pcwrite, ifid_write, ifid_flush, idex_flush, exmem_flush};
    assign ctrl4 = {pcwrite4, ifid_write4, ifid_flush4, idex_flush4, exmem_flush4};

    hazard_control_unit dut (
        .clk(clk), .reset(reset), .idex_memread(idex_memread), .idex_rt(idex_rt),
        .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .ifid_uses_rt(ifid_uses_rt),
        .branch_ex_mem(branch_ex_mem), .zero_flag_ex_mem(zero_flag_ex_mem), .jump(jump),
        .mem_busy(mem_busy), .pcwrite(pcwrite), .ifid_write(ifid_write),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_flush(exmem_flush),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    hazard_control_unit #(.CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .idex_memread(idex_memread), .idex_rt(idex_rt),
        .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .ifid_uses_rt(ifid_uses_rt),
        .branch_ex_mem(branch_ex_mem), .zero_flag_ex_mem(zero_flag_ex_mem), .jump(jump),
        .mem_busy(mem_busy), .pcwrite(pcwrite4), .ifid_write(ifid_write4),
        .ifid_flush(ifid_flush4), .idex_flush(idex_flush4), .exmem_flush(exmem_flush4),
        .stall_cnt(stall_cnt4), .flush_cnt(flush_cnt4)
    );

    function automatic logic [3:0] sat4(input logic [3:0] v);
        return (v == 4'd15) ? v : v + 4'd1;
    endfunction

    task automatic drive(input logic mr, input logic [4:0] rt, input logic [4:0] rs,
                         input logic [4:0] irt, input logic ur, input logic br,
                         input logic z, input logic j, input logic mb);
        idex_memread = mr; idex_rt = rt; ifid_rs = rs; ifid_rt = irt; ifid_uses_rt = ur;
        branch_ex_mem = br; zero_flag_ex_mem = z; jump = j; mem_busy = mb;
    endtask

    task automatic push(input string tag, input logic [4:0] c);
        exp_t e;
        e.tag = tag; e.ctrl = c; e.sc = m_sc; e.fc = m_fc; e.sc4 = m_sc4; e.fc4 = m_fc4;
        sb.push_back(e);
    endtask

    task automatic compare();
        exp_t e;
        checks++;
        assert (sb.size() != 0) else begin
            errors++;
            $error("FAIL scoreboard empty got 0 entries exp 1");
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            checks++;
            assert (ctrl === e.ctrl) else begin
                errors++; $error("FAIL %s ctrl got %b exp %b", e.tag, ctrl, e.ctrl);
            end
            checks++;
            assert (ctrl4 === e.ctrl) else begin
                errors++; $error("FAIL %s ctrl4 got %b exp %b", e.tag, ctrl4, e.ctrl);
            end
            checks++;
            assert (stall_cnt === e.sc) else begin
                errors++; $error("FAIL %s stall_cnt got %0d exp %0d", e.tag, stall_cnt, e.sc);
            end
            checks++;
            assert (flush_cnt === e.fc) else begin
                errors++; $error("FAIL %s flush_cnt got %0d exp %0d", e.tag, flush_cnt, e.fc);
            end
            checks++;
            assert (stall_cnt4 === e.sc4) else begin
                errors++; $error("FAIL %s stall_cnt4 got %0d exp %0d", e.tag, stall_cnt4, e.sc4);
            end
            checks++;
            assert (flush_cnt4 === e.fc4) else begin
                errors++; $error("FAIL %s flush_cnt4 got %0d exp %0d", e.tag, flush_cnt4, e.fc4);
            end
        end
    endtask

    // Check one cycle at the falling edge, then account for counter events at the rising edge.
    task automatic step(input string tag, input logic [4:0] c, input bit inc_s, input bit inc_f);
        push(tag, c);
        @(negedge clk);
        compare();
        @(posedge clk);
        #1;
        if (inc_s) begin m_sc = m_sc + 16'd1; m_sc4 = sat4(m_sc4); end
        if (inc_f) begin m_fc = m_fc + 16'd1; m_fc4 = sat4(m_fc4); end
    endtask

    initial begin
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        push("reset_init", RST);
        compare();
        @(posedge clk); #1;
        reset = 1'b1;
        step("idle", NORM, 0, 0);
        drive(1, 8, 8, 0, 0, 0, 0, 0, 0);
        step("lu_cycle1", STALL, 1, 0);
        step("lu_cycle2", NORM, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step("lu_after", NORM, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        step("rt_zero", NORM, 0, 0);
        drive(1, 9, 1, 9, 0, 0, 0, 0, 0);
        step("rt_unused", NORM, 0, 0);
        drive(1, 9, 1, 9, 1, 0, 0, 0, 0);
        step("rt_used", STALL, 1, 0);
        step("rt_used_hold", NORM, 0, 0);
        drive(1, 8, 8, 0, 0, 1, 1, 0, 0);
        step("br_beats_lu", BR, 0, 1);
        drive(0, 0, 0, 0, 0, 1, 0, 1, 0);
        step("br_not_taken_jump", JMP, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
        step("jump", JMP, 0, 0);
        drive(0, 0, 0, 0, 0, 1, 1, 0, 1);
        step("freeze1", FRZ, 0, 0);
        step("freeze2", FRZ, 0, 0);
        step("freeze3", FRZ, 0, 0);
        drive(0, 0, 0, 0, 0, 1, 1, 0, 0);
        step("freeze_end_br", BR, 0, 1);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step("post_freeze_idle", NORM, 0, 0);
        drive(1, 8, 8, 0, 0, 0, 0, 0, 0);
        step("lu_pre_freeze", STALL, 1, 0);
        mem_busy = 1'b1;
        step("lu_freeze", FRZ, 0, 0);
        mem_busy = 1'b0;
        step("lu_after_freeze", STALL, 1, 0);
        step("lu_after_freeze_hold", NORM, 0, 0);
        step("lu_fifth", STALL, 1, 0);
        reset = 1'b0;
        #1;
        m_sc = 0; m_fc = 0; m_sc4 = 0; m_fc4 = 0;
        push("reset_mid_stall", RST);
        compare();
        step("reset_hold", RST, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        #1;
        push("reset_release", NORM);
        compare();
        step("release_idle", NORM, 0, 0);
        drive(1, 8, 8, 0, 0, 0, 0, 0, 0);
        step("lu_after_reset", STALL, 1, 0);
        drive(0, 0, 0, 0, 0, 1, 1, 0, 0);
        for (int i = 0; i < 20; i++) step($sformatf("sat_br%0d", i), BR, 0, 1);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step("sat_hold", NORM, 0, 0);
        step("sat_hold2", NORM, 0, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/hazard_control_unit.md
# hazard_control_unit

Pipeline hazard controller for the 5-stage MIPS core; it produces the `pcwrite` enable and flush/write controls that the PC register and the IF/ID, ID/EX and EX/MEM pipeline registers consume. It detects load-use hazards, taken branches resolved in EX/MEM, jumps decoded in ID, and memory-busy freezes. A small FSM guarantees single-cycle load-use stalls. Saturating event counters support performance debug.

## Interface
- `CNT_W`, default 16: width of the performance counters.
- `clk` input 1: core clock, rising-edge.
- `reset` input 1: asynchronous, active-low reset.
- `idex_memread` input 1: the instruction in ID/EX is a load.
- `idex_rt` input 5: destination register of the load in ID/EX.
- `ifid_rs` input 5: rs field of the instruction in IF/ID.
- `ifid_rt` input 5: rt field of the instruction in IF/ID.
- `ifid_uses_rt` input 1: the IF/ID instruction reads rt as a source (R-type, beq, sw).
- `branch_ex_mem` input 1: the EX/MEM instruction is a branch.
- `zero_flag_ex_mem` input 1: ALU zero for that branch.
- `jump` input 1: the ID-stage instruction is a jump.
- `mem_busy` input 1: instruction or data memory is not ready; the pipeline must freeze.
- `pcwrite` output 1: PC register update enable.
- `ifid_write` output 1: IF/ID load enable.
- `ifid_flush` output 1: IF/ID is loaded with a NOP.
- `idex_flush` output 1: ID/EX is loaded with a bubble (control bits zero).
- `exmem_flush` output 1: EX/MEM control bits are cleared.
- `stall_cnt` output CNT_W: number of load-use stall cycles.
- `flush_cnt` output CNT_W: number of taken-branch flush events.

## Operation
- FSM states: RUN, LU_STALL, FREEZE. State and counters are registered; the control outputs are combinational from the state and the current inputs.
- Definitions:
  - `lu_haz` = idex_memread & (idex_rt != 0) & ((idex_rt == ifid_rs) | (ifid_uses_rt & idex_rt == ifid_rt)).
  - `br_taken` = branch_ex_mem & zero_flag_ex_mem.
- Priority, highest first: mem_busy, br_taken, jump, lu_haz.
- **mem_busy = 1** (any state):
  - Outputs: pcwrite=0, ifid_write=0, all flushes 0.
  - Next state is FREEZE.
  - No counter changes. Pending events are evaluated once the freeze ends, because the pipeline inputs are held.
- **FREEZE**, mem_busy = 0: evaluated exactly as RUN in that cycle.
- **br_taken**:
  - Outputs: pcwrite=1 (the PC loads the branch target), ifid_write=1, ifid_flush=1, idex_flush=1, exmem_flush=1.
  - Next state is RUN.
  - flush_cnt increments by 1.
  - This overrides jump and lu_haz in the same cycle.
- **jump** (no br_taken):
  - Outputs: pcwrite=1, ifid_write=1, ifid_flush=1, other flushes 0.
  - Next state is RUN.
- **lu_haz in RUN** (no higher event):
  - Outputs: pcwrite=0, ifid_write=0, idex_flush=1.
  - Next state is LU_STALL.
  - stall_cnt increments by 1.
- **LU_STALL** (no mem_busy, no br_taken, no jump):
  - lu_haz is ignored. Outputs are normal: pcwrite=1, ifid_write=1, flushes 0.
  - Next state is RUN.
  - This bounds every load-use stall to exactly one cycle.
- **Otherwise**: pcwrite=1, ifid_write=1, flushes 0; state stays RUN.
- **Counters**: unsigned, saturate at 2^CNT_W-1 and never wrap.

## Timing
- While reset is low, regardless of clk:
  - State is RUN; stall_cnt and flush_cnt are 0.
  - pcwrite=0, ifid_write=0, ifid_flush=1, idex_flush=1, exmem_flush=1.
- Outputs return to RUN defaults combinationally once reset deasserts.
- Reset asserted mid-stall or mid-freeze: state goes to RUN immediately; no residual stall after release.
- Control outputs have zero-cycle latency: they are valid within the same cycle as their inputs and are sampled by the PC and pipeline registers at the next rising clk.
- State and counter updates take effect at the rising clk edge.
- Taken-branch penalty is 3 flushed slots. Jump penalty is 1 slot. Load-use penalty is 1 cycle.

## Test plan
- **Reset**: drive reset=0 mid-operation with stall_cnt=5.
  - Required: counters read 0 immediately, pcwrite=0, all flushes 1.
  - After release with idle inputs: pcwrite=1 and ifid_write=1.
- **Load-use stall**: idex_memread=1, idex_rt=8, ifid_rs=8, held for 2 cycles.
  - Cycle 1: pcwrite=0, ifid_write=0, idex_flush=1.
  - Cycle 2 (LU_STALL): pcwrite=1.
  - stall_cnt=1.
- **Register $0 and rt gating**:
  - idex_rt=0, ifid_rs=0: no stall.
  - idex_rt=9, ifid_rt=9, ifid_uses_rt=0: no stall.
  - idex_rt=9, ifid_rt=9, ifid_uses_rt=1: stall.
- **Branch beats stall**: br_taken and lu_haz in the same cycle.
  - Required: pcwrite=1, all three flushes 1, stall_cnt unchanged, flush_cnt +1.
- **Freeze**: mem_busy=1 for 3 cycles with br_taken held.
  - Required: pcwrite=0 and no flush for 3 cycles.
  - In the 4th cycle (mem_busy=0): the flush fires once and flush_cnt increments exactly once.
- **Saturation**: CNT_W=4, 20 taken branches.
  - Required: flush_cnt=15 and holds at 15.
